// File: rtl/multi_word_adder_ctrl.sv
// multi_word_adder_ctrl: sequences a WIDTH*WORDS-bit add through an external
// WIDTH-bit combinational adder, one chunk per clock, least-significant first.
// Carry_out of each chunk is registered and fed back as the next chunk's carry.
// Optional feature: define OVERFLOW_FLAG_EN to add a signed-overflow output.

module multi_word_adder_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Op_valid,
  output logic                     Op_ready,
  input  logic [WIDTH*WORDS-1:0]   Op_A,
  input  logic [WIDTH*WORDS-1:0]   Op_B,
  input  logic                     Op_carry_in,
  output logic [WIDTH-1:0]         Adder_Data_1,
  output logic [WIDTH-1:0]         Adder_Data_2,
  output logic                     Adder_Carry_in,
  input  logic [WIDTH-1:0]         Adder_Sum,
  input  logic                     Adder_Carry_out,
  output logic [WIDTH*WORDS-1:0]   Result,
  output logic                     Carry_out,
`ifdef OVERFLOW_FLAG_EN
  output logic                     Overflow,
`endif
  output logic                     Res_valid,
  input  logic                     Res_ready
);

  localparam int unsigned TotalW = WIDTH * WORDS;
  localparam int unsigned IdxW   = $clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [IdxW-1:0]   idx_q,    idx_d;
  logic              carry_q,  carry_d;
  logic [TotalW-1:0] a_q,      a_d;
  logic [TotalW-1:0] b_q,      b_d;
  logic [TotalW-1:0] result_q, result_d;
  logic              cout_q,   cout_d;
`ifdef OVERFLOW_FLAG_EN
  logic              ovf_q,    ovf_d;
`endif

  logic running;
  assign running = (state_q == StRun);

  // Next-state: accept in idle, walk chunks in run, hold result until consumed.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (Op_valid) begin
          a_d     = Op_A;
          b_d     = Op_B;
          carry_d = Op_carry_in;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[idx_q*WIDTH +: WIDTH] = Adder_Sum;
        carry_d = Adder_Carry_out;
        if (idx_q == LastIdx) begin
          // Index stays at the last chunk; it is cleared only on the next accept.
          cout_d  = Adder_Carry_out;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = (a_q[TotalW-1] == b_q[TotalW-1]) &&
                    (Adder_Sum[WIDTH-1] != a_q[TotalW-1]);
`endif
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (Res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Outputs: adder is fed only while running, zero otherwise.
  always_comb begin
    Op_ready       = (state_q == StIdle);
    Res_valid      = (state_q == StDone);
    Result         = result_q;
    Carry_out      = cout_q;
    Adder_Data_1   = running ? a_q[idx_q*WIDTH +: WIDTH] : '0;
    Adder_Data_2   = running ? b_q[idx_q*WIDTH +: WIDTH] : '0;
    Adder_Carry_in = running ? carry_q : 1'b0;
`ifdef OVERFLOW_FLAG_EN
    Overflow       = ovf_q;
`endif
  end

endmodule

// File: doc/multi_word_adder_ctrl.md
Name: multi_word_adder_ctrl

Overview:
- Sequencer that performs a WIDTH*WORDS-bit add using the team's WIDTH-bit combinational Multiple_bits_Adder, one chunk per clock, least-significant chunk first.
- Sits directly upstream and downstream of the adder instance.
  - Upstream: drives Data_1, Data_2 and Carry_in.
  - Downstream: captures Sum and Carry_out into a result register and feeds each Carry_out back as the next chunk's Carry_in.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 4, chunk width; must match the attached adder's WIDTH.
- WORDS, 4, number of chunks (>= 2); full operand width = WIDTH*WORDS.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Op_valid  input  1  operand request
- Op_ready  output  1  block can accept operands
- Op_A  input  WIDTH*WORDS  operand A
- Op_B  input  WIDTH*WORDS  operand B
- Op_carry_in  input  1  carry into chunk 0
- Adder_Data_1  output  WIDTH  current chunk of A to adder
- Adder_Data_2  output  WIDTH  current chunk of B to adder
- Adder_Carry_in  output  1  carry into current chunk
- Adder_Sum  input  WIDTH  adder sum
- Adder_Carry_out  input  1  adder carry out
- Result  output  WIDTH*WORDS  full sum
- Carry_out  output  1  final carry
- Res_valid  output  1  Result/Carry_out valid
- Res_ready  input  1  consumer accepts result

Behaviour:
- One clock (Clk). Reset is synchronous and active-high: sampled only on the rising edge of Clk.
- Reset values:
  - State = IDLE, chunk index = 0, carry register = 0.
  - Op_ready = 1, Res_valid = 0, Result = 0, Carry_out = 0.
  - Adder_Data_1 = 0, Adder_Data_2 = 0, Adder_Carry_in = 0.
- States and transitions:
  - IDLE: Op_ready = 1. On Op_valid && Op_ready, latch Op_A, Op_B and Op_carry_in into internal registers; index = 0; carry register = Op_carry_in; go to RUN.
  - RUN: Op_ready = 0.
    - Adder_Data_1/Adder_Data_2 = chunk[index] of the latched operands; Adder_Carry_in = carry register.
    - Each edge: Result[index*WIDTH +: WIDTH] <= Adder_Sum; carry register <= Adder_Carry_out; index++.
    - When index == WORDS-1: also Carry_out <= Adder_Carry_out, go to DONE.
  - DONE: Res_valid = 1; Result and Carry_out held stable. On Res_ready = 1, Res_valid drops next cycle and state returns to IDLE.
- Latency: handshake edge (cycle 0) -> WORDS RUN cycles -> Res_valid high on cycle WORDS+1.
  - Throughput: one op per WORDS+2 cycles when Res_ready is held high.
- Adder outputs driven to 0 in IDLE and DONE.
- Arithmetic: {Carry_out, Result} == Op_A + Op_B + Op_carry_in, computed at WIDTH*WORDS+1 bits with no truncation.
- Boundary conditions:
  - Op_valid while in RUN/DONE: ignored; Op_ready is low. Operands changing after acceptance have no effect.
  - Res_ready held low: stays in DONE indefinitely with outputs stable.
  - Res_ready already high on DONE entry: Res_valid is high for exactly one cycle.
  - Carry propagation across every chunk boundary, including all-ones operands.
  - Index wraps to 0 only via IDLE; it never exceeds WORDS-1.
  - Reset mid-RUN or in DONE: returns to the reset values on that edge; any partial result is discarded.
  - Reset has priority over every other event in the same cycle.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- Defined:
  - Extra output port Overflow (1 bit), reset 0, captured on the last RUN edge alongside Carry_out and valid with Res_valid.
  - Computed as signed two's-complement overflow of the full-width add: sign(A) == sign(B) && sign(Result) != sign(A).
  - For this check, sign(A) and sign(B) are the MSBs of the latched operands and sign(Result) is the MSB of Adder_Sum on the last chunk.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=4, WORDS=4):
- Basic chunk carry: A=0x00FF, B=0x0001, cin=0 -> Result=0x0100, Carry_out=0. Res_valid rises exactly 5 cycles after the handshake edge; Adder_Carry_in=1 observed on chunks 1 and 2.
- Full carry chain: A=0xFFFF, B=0x0000, cin=1 -> Result=0x0000, Carry_out=1. Also A=0x1234, B=0x4321, cin=0 -> Result=0x5555, Carry_out=0.
- Backpressure and busy-ignore:
  - Hold Res_ready=0 for 10 cycles: Result/Res_valid stable. Then pulse Res_ready=1 for one cycle: Res_valid low next cycle, Op_ready=1.
  - Op_valid pulsed during RUN (A=0xAAAA) must not alter the in-flight result.
- Reset mid-operation: assert Reset on the 2nd RUN cycle -> next cycle Op_ready=1, Res_valid=0, Result=0, Carry_out=0. A following op (A=0x0003, B=0x0004, cin=1) gives 0x0008.
- Overflow (OVERFLOW_FLAG_EN): 0x7FFF+0x0001 -> Result 0x8000, Overflow=1, Carry_out=0; 0x8000+0x8000 -> Result 0x0000, Overflow=1, Carry_out=1; 0x0001+0xFFFF -> Result 0x0000, Overflow=0.
- Random: 500 ops with random A, B, cin and random Res_ready stalls -> scoreboard {Carry_out, Result} against a 17-bit reference sum; zero mismatches.
